// File: rtl/aict_intercon.sv
// aict_intercon: hs32 master to NS memory-mapped slots plus SRAM fallback.
// Relocatable decode window, per-slot enables, bus timeout and fault-address capture.
module aict_intercon #(
  parameter int                     NS         = 4,
  parameter int                     MASK_LEN   = 8,
  parameter logic [MASK_LEN*NS-1:0] BASE       = '0,
  parameter logic [MASK_LEN*NS-1:0] MASK       = '0,
  parameter int                     TIMEOUT    = 255,
  parameter logic [31:0]            RESET_BASE = 32'h0000_FF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_stb,
  output logic                o_ack,
  output logic                o_err,
  input  logic [31:0]         i_addr,
  output logic [31:0]         o_dtr,
  input  logic [31:0]         i_dtw,
  input  logic                i_rw,
  input  logic [32*NS-1:0]    i_dtr,
  input  logic [NS-1:0]       i_ack,
  output logic [NS-1:0]       o_stb,
  output logic [MASK_LEN-1:0] o_addr,
  output logic                sstb,
  input  logic                sack,
  input  logic [31:0]         sdtr
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                o_ack_q, o_ack_d;
  logic                o_err_q, o_err_d;
  logic [31:0]         o_dtr_q, o_dtr_d;
  logic [NS-1:0]       o_stb_q, o_stb_d;
  logic                sstb_q, sstb_d;
  logic [MASK_LEN-1:0] o_addr_q, o_addr_d;
  logic [SW-1:0]       sel_q, sel_d;
  logic                sram_q, sram_d;
  logic                rw_q, rw_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         base_q, base_d;
  logic [NS-1:0]       en_q, en_d;
  logic [31:0]         err_addr_q, err_addr_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [MASK_LEN-1:0] off_s;
  logic                win_s, ctrl_s, hit_s, sel_ack_s;
  logic [SW-1:0]       idx_s;
  logic [31:0]         ctrl_rd_s, sel_dat_s;

  // Address decode: control registers take priority, then the lowest matching slot.
  always_comb begin
    off_s  = i_addr[MASK_LEN-1:0];
    win_s  = (i_addr[31:MASK_LEN] == base_q[31:MASK_LEN]);
    ctrl_s = win_s && ((off_s == MASK_LEN'(0)) || (off_s == MASK_LEN'(4)) ||
                       (off_s == MASK_LEN'(8)));
    hit_s  = 1'b0;
    idx_s  = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (win_s && ((off_s & MASK[i*MASK_LEN +: MASK_LEN]) == BASE[i*MASK_LEN +: MASK_LEN])) begin
        hit_s = 1'b1;
        idx_s = SW'(i);
      end
    end
    case (off_s)
      MASK_LEN'(0): ctrl_rd_s = base_q;
      MASK_LEN'(4): ctrl_rd_s = {{(32-NS){1'b0}}, en_q};
      default:      ctrl_rd_s = err_addr_q;
    endcase
    sel_ack_s = sram_q ? sack : i_ack[sel_q];
    sel_dat_s = sram_q ? sdtr : i_dtr[sel_q*32 +: 32];
  end

  // Transaction FSM next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    o_ack_d    = 1'b0;
    o_err_d    = 1'b0;
    o_dtr_d    = o_dtr_q;
    o_stb_d    = '0;
    sstb_d     = 1'b0;
    o_addr_d   = o_addr_q;
    sel_d      = sel_q;
    sram_d     = sram_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    base_d     = base_q;
    en_d       = en_q;
    err_addr_d = err_addr_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_stb) begin
          o_addr_d = off_s;
          rw_d     = i_rw;
          addr_d   = i_addr;
          sel_d    = idx_s;
          sram_d   = !hit_s;
          cnt_d    = '0;
          if (ctrl_s) begin
            state_d = S_RESP;
            o_ack_d = 1'b1;
            o_dtr_d = i_rw ? 32'h0000_0000 : ctrl_rd_s;
            if (i_rw && (off_s == MASK_LEN'(0))) begin
              base_d = i_dtw;
            end else if (i_rw && (off_s == MASK_LEN'(4))) begin
              en_d = i_dtw[NS-1:0];
            end else begin
              en_d = en_q;
            end
          end else if (hit_s && !en_q[idx_s]) begin
            state_d    = S_RESP;
            o_ack_d    = 1'b1;
            o_err_d    = 1'b1;
            o_dtr_d    = 32'h0000_0000;
            err_addr_d = i_addr;
          end else begin
            state_d = S_BUSY;
            o_stb_d = hit_s ? (NS'(1) << idx_s) : '0;
            sstb_d  = !hit_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (sel_ack_s) begin
          state_d = S_RESP;
          o_ack_d = 1'b1;
          o_dtr_d = rw_q ? 32'h0000_0000 : sel_dat_s;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d    = S_RESP;
          o_ack_d    = 1'b1;
          o_err_d    = 1'b1;
          o_dtr_d    = 32'h0000_0000;
          err_addr_d = addr_q;
        end else begin
          o_stb_d = o_stb_q;
          sstb_d  = sstb_q;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset wins over any pending acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      o_ack_q    <= 1'b0;
      o_err_q    <= 1'b0;
      o_dtr_q    <= 32'h0000_0000;
      o_stb_q    <= '0;
      sstb_q     <= 1'b0;
      o_addr_q   <= '0;
      sel_q      <= '0;
      sram_q     <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= 32'h0000_0000;
      base_q     <= RESET_BASE;
      en_q       <= '1;
      err_addr_q <= 32'h0000_0000;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      o_ack_q    <= o_ack_d;
      o_err_q    <= o_err_d;
      o_dtr_q    <= o_dtr_d;
      o_stb_q    <= o_stb_d;
      sstb_q     <= sstb_d;
      o_addr_q   <= o_addr_d;
      sel_q      <= sel_d;
      sram_q     <= sram_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      base_q     <= base_d;
      en_q       <= en_d;
      err_addr_q <= err_addr_d;
      cnt_q      <= cnt_d;
`ifdef SIM
      if (base_d != base_q) $display("aict_intercon: window base now %h", base_d);
`endif
    end
  end

  assign o_ack  = o_ack_q;
  assign o_err  = o_err_q;
  assign o_dtr  = o_dtr_q;
  assign o_stb  = o_stb_q;
  assign sstb   = sstb_q;
  assign o_addr = o_addr_q;

endmodule

// File: tb/tb_aict_intercon.sv
// Randomized self-checking bench for aict_intercon: a per-transaction timeline model
// feeds an expectation queue that one negedge compare process drains.
module tb_aict_intercon;
  localparam int NS = 4;
  localparam int TO = 8;
  // packed {slot3, slot2, slot1, slot0}
  localparam logic [31:0] BASE_P = {8'h40, 8'h40, 8'h10, 8'h20};
  localparam logic [31:0] MASK_P = {8'hC0, 8'hE0, 8'hF0, 8'hF0};

  logic        clk = 1'b0;
  logic        reset, i_stb, i_rw, sack, sstb, o_ack, o_err;
  logic [31:0] i_addr, i_dtw, sdtr, o_dtr;
  logic [127:0] i_dtr;
  logic [3:0]  i_ack, o_stb;
  logic [7:0]  o_addr;

  aict_intercon #(.NS(NS), .MASK_LEN(8), .BASE(BASE_P), .MASK(MASK_P), .TIMEOUT(TO),
                  .RESET_BASE(32'h0000_FF00)) dut (
    .clk(clk), .reset(reset), .i_stb(i_stb), .o_ack(o_ack), .o_err(o_err),
    .i_addr(i_addr), .o_dtr(o_dtr), .i_dtw(i_dtw), .i_rw(i_rw), .i_dtr(i_dtr),
    .i_ack(i_ack), .o_stb(o_stb), .o_addr(o_addr), .sstb(sstb), .sack(sack), .sdtr(sdtr));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  stb;
    logic        sstb;
    logic        ack;
    logic        err;
    logic [31:0] dtr;
    logic        chk_dtr;
    logic        chk_addr;
    logic [7:0]  addr;
  } exp_t;

  exp_t        expq[$];
  exp_t        ce;
  int          total = 0;
  int          bad = 0;
  logic        chk_en = 1'b0;
  logic [31:0] last_dtr = 32'h0;
  logic        last_err = 1'b0;

  // Reference state of the software-visible registers.
  logic [31:0] m_base;
  logic [3:0]  m_en;
  logic [31:0] m_erra;
  logic [7:0]  sb[NS] = '{8'h20, 8'h10, 8'h40, 8'h40};
  logic [7:0]  sm[NS] = '{8'hF0, 8'hF0, 8'hE0, 8'hC0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      if (expq.size() > 0) begin
        ce = expq.pop_front();
        chk("o_stb", {28'h0, o_stb}, {28'h0, ce.stb});
        chk("sstb", {31'h0, sstb}, {31'h0, ce.sstb});
        chk("o_ack", {31'h0, o_ack}, {31'h0, ce.ack});
        if (ce.ack) chk("o_err", {31'h0, o_err}, {31'h0, ce.err});
        if (ce.chk_dtr) chk("o_dtr", o_dtr, ce.dtr);
        if (ce.chk_addr) chk("o_addr", {24'h0, o_addr}, {24'h0, ce.addr});
      end else begin
        chk("idle_stb", {27'h0, sstb, o_stb}, 32'h0);
        chk("idle_ack", {31'h0, o_ack}, 32'h0);
      end
      if (o_ack) begin
        last_dtr = o_dtr;
        last_err = o_err;
      end
    end
  end

  // kind: 0 control register, 1 device slot, 2 SRAM
  function automatic void decode(input logic [31:0] a, output int kind, output int idx);
    logic [7:0] off;
    off  = a[7:0];
    kind = 2;
    idx  = 0;
    if (a[31:8] == m_base[31:8]) begin
      if (off == 8'h00 || off == 8'h04 || off == 8'h08) kind = 0;
      else
        for (int i = 0; i < NS; i++)
          if (kind == 2 && (off & sm[i]) == sb[i]) begin
            kind = 1;
            idx  = i;
          end
    end
  endfunction

  // d = BUSY cycle (1-based) in which the target acks; 0 = never
  task automatic do_txn(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                        input int d, input logic [31:0] dd);
    int kind, idx, nbusy;
    logic err;
    logic [31:0] rdat;
    exp_t e;
    decode(a, kind, idx);
    err = 1'b0;
    rdat = 32'h0;
    nbusy = 0;
    if (kind == 0) begin
      if (a[7:0] == 8'h00) rdat = m_base;
      else if (a[7:0] == 8'h04) rdat = {28'h0, m_en};
      else rdat = m_erra;
      if (rw && a[7:0] == 8'h00) m_base = wd;
      if (rw && a[7:0] == 8'h04) m_en = wd[3:0];
    end else if (kind == 1 && !m_en[idx]) begin
      err = 1'b1;
      m_erra = a;
    end else if (d >= 1 && d <= TO) begin
      nbusy = d;
      rdat = dd;
    end else begin
      nbusy = TO;
      err = 1'b1;
      m_erra = a;
    end
    if (err) rdat = 32'h0;
    e = '{default: '0};
    expq.push_back(e);
    for (int k = 0; k < nbusy; k++) begin
      e = '{default: '0};
      e.stb = (kind == 1) ? 4'(1 << idx) : 4'h0;
      e.sstb = (kind == 2);
      e.chk_addr = 1'b1;
      e.addr = a[7:0];
      expq.push_back(e);
    end
    e = '{default: '0};
    e.ack = 1'b1;
    e.err = err;
    e.dtr = rdat;
    e.chk_dtr = !rw || err;
    e.chk_addr = 1'b1;
    e.addr = a[7:0];
    expq.push_back(e);
    i_stb = 1'b1; i_addr = a; i_rw = rw; i_dtw = wd;
    for (int c = 0; c < nbusy + 2; c++) begin
      i_ack = 4'($urandom_range(0, 15));
      i_dtr = {$urandom, $urandom, $urandom, $urandom};
      sack = 1'($urandom_range(0, 1));
      sdtr = $urandom;
      if (kind == 1) begin
        i_ack[idx] = (c == d && c >= 1);
        if (c == d) i_dtr[idx*32 +: 32] = dd;
      end
      if (kind == 2) begin
        sack = (c == d && c >= 1);
        if (c == d) sdtr = dd;
      end
      @(posedge clk); #1;
    end
    i_stb = 1'b0; i_ack = 4'h0; sack = 1'b0;
  endtask

  task automatic reset_model();
    m_base = 32'h0000_FF00;
    m_en = 4'hF;
    m_erra = 32'h0;
  endtask

  task automatic chk_reset_outputs(input string nm);
    @(negedge clk);
    chk({nm, "_stb"}, {27'h0, sstb, o_stb}, 32'h0);
    chk({nm, "_ack"}, {30'h0, o_ack, o_err}, 32'h0);
    chk({nm, "_dtr"}, o_dtr, 32'h0);
    chk({nm, "_addr"}, {24'h0, o_addr}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, wd;
    int r;
    exp_t e;
    reset = 1'b1; i_stb = 1'b0; i_rw = 1'b0; i_addr = 32'h0; i_dtw = 32'h0;
    i_dtr = '0; i_ack = 4'h0; sack = 1'b0; sdtr = 32'h0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk_reset_outputs("rst");

    do_txn(32'h0000_FF00, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_base_rd", last_dtr, 32'h0000_FF00);
    do_txn(32'h0000_FF04, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_en_rd", last_dtr, 32'h0000_000F);
    do_txn(32'h0000_FF00, 1'b1, 32'h0001_0000, 0, 32'h0);
    do_txn(32'h0001_0000, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_reloc_rd", last_dtr, 32'h0001_0000);
    do_txn(32'h0000_FF10, 1'b0, 32'h0, 2, 32'h1234_5678);
    do_txn(32'h0001_0000, 1'b1, 32'h0000_FF00, 0, 32'h0);
    do_txn(32'h0000_FF10, 1'b0, 32'h0, 3, 32'hCAFE_F00D);
    chk("pin_slot1_rd", last_dtr, 32'hCAFE_F00D);
    do_txn(32'h0000_FF14, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_timeout_err", {31'h0, last_err}, 32'h1);
    do_txn(32'h0000_FF08, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_err_addr", last_dtr, 32'h0000_FF14);
    do_txn(32'h0000_FF18, 1'b0, 32'h0, 8, 32'h5A5A_0008);
    chk("pin_ack_at_limit", {31'h0, last_err}, 32'h0);
    do_txn(32'h0000_FF18, 1'b0, 32'h0, 9, 32'h5A5A_0009);
    chk("pin_ack_late", {31'h0, last_err}, 32'h1);
    do_txn(32'h0000_FF04, 1'b1, 32'h0000_000D, 0, 32'h0);
    do_txn(32'h0000_FF1C, 1'b0, 32'h0, 1, 32'h0);
    chk("pin_disabled_err", {31'h0, last_err}, 32'h1);
    do_txn(32'h0000_FF08, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_dis_err_addr", last_dtr, 32'h0000_FF1C);
    do_txn(32'h0000_FF04, 1'b1, 32'h0000_000F, 0, 32'h0);
    do_txn(32'h0000_FF48, 1'b0, 32'h0, 2, 32'h0000_0048);
    do_txn(32'h0000_FF68, 1'b1, 32'h1, 4, 32'h0);
    do_txn(32'h0000_FF28, 1'b0, 32'h0, 1, 32'h0000_0028);

    // reset while a slot-1 access is in BUSY with its ack pending
    i_stb = 1'b1; i_addr = 32'h0000_FF10; i_rw = 1'b0;
    e = '{default: '0};
    expq.push_back(e);
    e.stb = 4'b0010; e.chk_addr = 1'b1; e.addr = 8'h10;
    expq.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; i_stb = 1'b0; i_ack = 4'b0010; i_dtr = '1;
    @(posedge clk); #1;
    reset = 1'b0; i_ack = 4'h0;
    reset_model();
    chk_reset_outputs("midrst");
    do_txn(32'h0000_FF00, 1'b0, 32'h0, 0, 32'h0);
    chk("pin_base_after_rst", last_dtr, 32'h0000_FF00);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r <= 3) a = {m_base[31:8], 8'(4 * $urandom_range(0, 2))};
      else a = {m_base[31:8], 8'($urandom)};
      wd = $urandom;
      if (a[7:0] == 8'h00) wd = ($urandom_range(0, 1) == 1) ? 32'h0000_FF00 : {24'h00AB_CD, 8'($urandom)};
      do_txn(a, 1'($urandom_range(0, 1)), wd, $urandom_range(0, 10), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    chk("expq_drained", expq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1);
  end
endmodule
